// File: rtl/diff_resp_checker.sv
// Output-side comparator for the equivalence harness: buffers model (A) and netlist (B)
// response streams, compares them pairwise, records the first mismatch and folds A into a MISR.
module diff_resp_checker #(
    parameter int          WIDTH       = 360,
    parameter int          DEPTH       = 4,
    parameter int          NUM_VECTORS = 20,
    parameter int          TIMEOUT     = 64,
    parameter logic [31:0] POLY        = 32'h04C11DB7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_data,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [15:0]      cmp_count,
    output logic [15:0]      mismatch_count,
    output logic [15:0]      first_idx,
    output logic             first_valid,
    output logic [WIDTH-1:0] first_a,
    output logic [WIDTH-1:0] first_b,
    output logic [31:0]      signature
);

    localparam int          AW        = $clog2(DEPTH);
    localparam int          NSLICE    = (WIDTH + 31) / 32;
    localparam logic [AW:0] FULL_CNT  = (AW + 1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);
    localparam logic [AW:0] PTR_ZERO  = (AW + 1)'(0);
    localparam logic [15:0] LAST_CMP  = 16'(NUM_VECTORS - 1);
    localparam logic [15:0] LAST_IDLE = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // XOR of the 32-bit slices of a word, zero-padded above WIDTH.
    function automatic logic [31:0] fold(input logic [WIDTH-1:0] d);
        logic [NSLICE*32-1:0] pad;
        logic [31:0]          acc;
        pad            = '0;
        pad[WIDTH-1:0] = d;
        acc            = 32'h0;
        for (int i = 0; i < NSLICE; i++) begin
            acc = acc ^ pad[i*32 +: 32];
        end
        return acc;
    endfunction

    state_t             r_state;
    state_t             w_state_nx;
    logic [WIDTH-1:0]   r_a_mem [DEPTH];
    logic [WIDTH-1:0]   r_b_mem [DEPTH];
    logic [AW:0]        r_a_wr, r_a_rd, r_b_wr, r_b_rd;
    logic               r_a_ready, r_b_ready;
    logic               r_done, r_pass, r_timeout, r_first_valid;
    logic [15:0]        r_cmp_count, r_mismatch_count, r_first_idx, r_idle_cnt;
    logic [WIDTH-1:0]   r_first_a, r_first_b;
    logic [31:0]        r_sig;

    logic [AW:0]        w_a_cnt, w_b_cnt, w_a_cnt_nx, w_b_cnt_nx;
    logic               w_a_empty, w_b_empty, w_a_push, w_b_push;
    logic               w_cmp, w_diff, w_last_cmp, w_to_hit;
    logic [WIDTH-1:0]   w_a_head, w_b_head;
    logic [15:0]        w_mm_nx;
    logic [31:0]        w_sig_nx;

    assign w_a_cnt    = r_a_wr - r_a_rd;
    assign w_b_cnt    = r_b_wr - r_b_rd;
    assign w_a_empty  = (w_a_cnt == PTR_ZERO);
    assign w_b_empty  = (w_b_cnt == PTR_ZERO);
    assign w_a_push   = a_valid && r_a_ready;
    assign w_b_push   = b_valid && r_b_ready;
    assign w_a_head   = r_a_mem[r_a_rd[AW-1:0]];
    assign w_b_head   = r_b_mem[r_b_rd[AW-1:0]];

    // A pending start discards this cycle's compare; the run is being restarted anyway.
    assign w_cmp      = (r_state == S_RUN) && !start && !w_a_empty && !w_b_empty;
    assign w_diff     = w_cmp && (w_a_head != w_b_head);
    assign w_last_cmp = w_cmp && (r_cmp_count == LAST_CMP);
    assign w_to_hit   = (r_state == S_RUN) && !start && !w_cmp && (r_idle_cnt == LAST_IDLE);
    assign w_mm_nx    = (w_diff && (r_mismatch_count != 16'hFFFF)) ? r_mismatch_count + 16'd1
                                                                   : r_mismatch_count;
    assign w_sig_nx   = {r_sig[30:0], 1'b0} ^ (r_sig[31] ? POLY : 32'h0) ^ fold(w_a_head);
    assign w_a_cnt_nx = w_a_cnt + {{AW{1'b0}}, w_a_push} - {{AW{1'b0}}, w_cmp};
    assign w_b_cnt_nx = w_b_cnt + {{AW{1'b0}}, w_b_push} - {{AW{1'b0}}, w_cmp};

    // Next-state logic for the run controller.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nx = S_RUN;
                else       w_state_nx = S_IDLE;
            end
            S_RUN: begin
                if (start)                        w_state_nx = S_RUN;
                else if (w_last_cmp || w_to_hit)  w_state_nx = S_DONE;
                else                              w_state_nx = S_RUN;
            end
            S_DONE: begin
                if (start) w_state_nx = S_RUN;
                else       w_state_nx = S_DONE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // State register, FIFO pointers and registered readies (next-cycle not-full).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a_wr    <= PTR_ZERO;
            r_a_rd    <= PTR_ZERO;
            r_b_wr    <= PTR_ZERO;
            r_b_rd    <= PTR_ZERO;
            r_a_ready <= 1'b0;
            r_b_ready <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_a_ready <= (w_state_nx == S_RUN) && (start || (w_a_cnt_nx != FULL_CNT));
            r_b_ready <= (w_state_nx == S_RUN) && (start || (w_b_cnt_nx != FULL_CNT));
            if (start) begin
                r_a_wr <= PTR_ZERO;
                r_a_rd <= PTR_ZERO;
                r_b_wr <= PTR_ZERO;
                r_b_rd <= PTR_ZERO;
            end else begin
                if (w_a_push) r_a_wr <= r_a_wr + PTR_ONE;
                if (w_b_push) r_b_wr <= r_b_wr + PTR_ONE;
                if (w_cmp) begin
                    r_a_rd <= r_a_rd + PTR_ONE;
                    r_b_rd <= r_b_rd + PTR_ONE;
                end
            end
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (w_a_push) r_a_mem[r_a_wr[AW-1:0]] <= a_data;
        if (w_b_push) r_b_mem[r_b_wr[AW-1:0]] <= b_data;
    end

    // Compare results, first-mismatch capture, signature and timeout tracking.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_timeout        <= 1'b0;
            r_cmp_count      <= 16'd0;
            r_mismatch_count <= 16'd0;
            r_first_idx      <= 16'd0;
            r_first_valid    <= 1'b0;
            r_first_a        <= '0;
            r_first_b        <= '0;
            r_sig            <= 32'h0;
            r_idle_cnt       <= 16'd0;
        end else if (w_cmp) begin
            r_cmp_count      <= r_cmp_count + 16'd1;
            r_mismatch_count <= w_mm_nx;
            r_sig            <= w_sig_nx;
            r_idle_cnt       <= 16'd0;
            if (w_diff && !r_first_valid) begin
                r_first_valid <= 1'b1;
                r_first_idx   <= r_cmp_count;
                r_first_a     <= w_a_head;
                r_first_b     <= w_b_head;
            end
            if (w_last_cmp) begin
                r_done <= 1'b1;
                r_pass <= (w_mm_nx == 16'd0);
            end
        end else if (r_state == S_RUN) begin
            r_idle_cnt <= r_idle_cnt + 16'd1;
            if (w_to_hit) begin
                r_done    <= 1'b1;
                r_timeout <= 1'b1;
                r_pass    <= 1'b0;
            end
        end
    end

    assign a_ready        = r_a_ready;
    assign b_ready        = r_b_ready;
    assign done           = r_done;
    assign pass           = r_pass;
    assign timeout        = r_timeout;
    assign cmp_count      = r_cmp_count;
    assign mismatch_count = r_mismatch_count;
    assign first_idx      = r_first_idx;
    assign first_valid    = r_first_valid;
    assign first_a        = r_first_a;
    assign first_b        = r_first_b;
    assign signature      = r_sig;

endmodule

// File: tb/tb_diff_resp_checker.sv
// Directed bench for diff_resp_checker: a cycle model with word queues as the scoreboard,
// checked every cycle with immediate assertions plus targeted checks per scenario.
module tb_diff_resp_checker;

    localparam int          WIDTH = 360;
    localparam int          DEPTH = 4;
    localparam int          NV    = 20;
    localparam int          TO    = 64;
    localparam logic [31:0] POLY  = 32'h04C11DB7;

    logic             clk = 1'b0;
    logic             rst, start, a_valid, b_valid;
    logic [WIDTH-1:0] a_data, b_data;
    logic             a_ready, b_ready, done, pass, timeout, first_valid;
    logic [15:0]      cmp_count, mismatch_count, first_idx;
    logic [WIDTH-1:0] first_a, first_b;
    logic [31:0]      signature;

    always #5 clk = ~clk;

    diff_resp_checker dut (
        .clk(clk), .rst(rst), .start(start),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
        .done(done), .pass(pass), .timeout(timeout),
        .cmp_count(cmp_count), .mismatch_count(mismatch_count),
        .first_idx(first_idx), .first_valid(first_valid),
        .first_a(first_a), .first_b(first_b), .signature(signature)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int n_ticks  = 0;

    // scoreboard: words accepted by the DUT, popped when the model says a compare fires
    logic [WIDTH-1:0] q_a[$];
    logic [WIDTH-1:0] q_b[$];
    bit               m_run, m_done, m_pass, m_to, m_fv;
    int               m_cmp, m_mm, m_idle, m_fidx;
    logic [WIDTH-1:0] m_fa, m_fb;
    logic [31:0]      m_sig;
    logic [WIDTH-1:0] wa[NV];
    logic [WIDTH-1:0] wb[NV];

    function automatic logic [31:0] ref_fold(input logic [WIDTH-1:0] d);
        logic [31:0] f = 32'h0;
        for (int i = 0; i < WIDTH; i++) f[i % 32] = f[i % 32] ^ d[i];
        return f;
    endfunction

    function automatic logic [WIDTH-1:0] rnd_word();
        logic [383:0] t;
        for (int i = 0; i < 12; i++) t[i*32 +: 32] = $urandom;
        return t[WIDTH-1:0];
    endfunction

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q_a.delete(); q_b.delete();
        m_done = 0; m_pass = 0; m_to = 0; m_fv = 0;
        m_cmp = 0; m_mm = 0; m_idle = 0; m_fidx = 0;
        m_fa = '0; m_fb = '0; m_sig = 32'h0;
    endtask

    task automatic check_outputs();
        chk("cmp_count", cmp_count, m_cmp);
        chk("mismatch_count", mismatch_count, m_mm);
        chk("signature", signature, m_sig);
        chk("done", done, m_done);
        chk("pass", pass, m_pass);
        chk("timeout", timeout, m_to);
        chk("first_valid", first_valid, m_fv);
        chk("first_idx", first_idx, m_fidx);
        chk("first_a", first_a, m_fa);
        chk("first_b", first_b, m_fb);
    endtask

    task automatic tick(output bit ax, output bit bx);
        bit fire, ra, rb;
        logic [WIDTH-1:0] ha, hb;
        @(negedge clk);
        ra = m_run && (q_a.size() < DEPTH);
        rb = m_run && (q_b.size() < DEPTH);
        chk("a_ready", a_ready, ra);
        chk("b_ready", b_ready, rb);
        ax   = a_valid && ra;
        bx   = b_valid && rb;
        fire = m_run && !start && !rst && (q_a.size() > 0) && (q_b.size() > 0);
        @(posedge clk);
        #1;
        n_ticks++;
        if (rst) begin
            model_clear(); m_run = 0;
        end else if (start) begin
            model_clear(); m_run = 1;
        end else begin
            if (fire) begin
                ha = q_a.pop_front();
                hb = q_b.pop_front();
                if (ha !== hb) begin
                    if (!m_fv) begin
                        m_fv = 1; m_fidx = m_cmp; m_fa = ha; m_fb = hb;
                    end
                    m_mm++;
                end
                m_sig = {m_sig[30:0], 1'b0} ^ (m_sig[31] ? POLY : 32'h0) ^ ref_fold(ha);
                m_cmp++;
                m_idle = 0;
                if (m_cmp == NV) begin
                    m_run = 0; m_done = 1; m_pass = (m_mm == 0);
                end
            end else if (m_run) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_run = 0; m_done = 1; m_to = 1; m_pass = 0;
                end
            end
            if (ax) q_a.push_back(a_data);
            if (bx) q_b.push_back(b_data);
        end
        check_outputs();
    endtask

    task automatic idle_tick();
        bit ax, bx;
        tick(ax, bx);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        idle_tick();
        start = 1'b0;
    endtask

    task automatic send(input int a_lo, input int a_hi, input int b_lo, input int b_hi);
        int ia = a_lo;
        int ib = b_lo;
        int guard = 0;
        bit ax, bx;
        while ((ia < a_hi || ib < b_hi) && guard < 200) begin
            a_valid = (ia < a_hi);
            a_data  = (ia < a_hi) ? wa[ia] : '0;
            b_valid = (ib < b_hi);
            b_data  = (ib < b_hi) ? wb[ib] : '0;
            tick(ax, bx);
            if (ax) ia++;
            if (bx) ib++;
            guard++;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        chk("send_complete", (ia == a_hi) && (ib == b_hi), 1'b1);
    endtask

    task automatic wait_done(input int limit);
        int cyc = 0;
        while (done !== 1'b1 && cyc < limit) begin
            idle_tick();
            cyc++;
        end
        chk("done_reached", done, 1'b1);
    endtask

    task automatic new_words(input int flip_idx);
        for (int i = 0; i < NV; i++) begin
            wa[i] = rnd_word();
            wb[i] = wa[i];
        end
        if (flip_idx >= 0) wb[flip_idx][WIDTH-1] = ~wb[flip_idx][WIDTH-1];
    endtask

    initial begin
        int t0;
        rst = 1'b1; start = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        a_data = '0; b_data = '0;
        model_clear(); m_run = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_ready", a_ready, 1'b0);
        chk("rst_b_ready", b_ready, 1'b0);
        check_outputs();
        rst = 1'b0;

        // equal streams, back-to-back
        new_words(-1);
        pulse_start();
        t0 = n_ticks;
        send(0, NV, 0, NV);
        wait_done(50);
        chk("eq_latency", n_ticks - t0, 21);
        chk("eq_pass", pass, 1'b1);
        chk("eq_mismatch", mismatch_count, 16'd0);
        chk("eq_first_valid", first_valid, 1'b0);

        // single mismatch at index 7 (B MSB flipped)
        new_words(7);
        pulse_start();
        send(0, NV, 0, NV);
        wait_done(50);
        chk("mm_count", mismatch_count, 16'd1);
        chk("mm_first_idx", first_idx, 16'd7);
        chk("mm_first_a", first_a, wa[7]);
        chk("mm_first_b", first_b, wb[7]);
        chk("mm_pass", pass, 1'b0);
        chk("mm_done", done, 1'b1);

        // restart from DONE after the failing run
        new_words(-1);
        pulse_start();
        chk("rs_cmp", cmp_count, 16'd0);
        chk("rs_first_valid", first_valid, 1'b0);
        chk("rs_signature", signature, 32'h0);
        chk("rs_a_ready", a_ready, 1'b1);
        chk("rs_b_ready", b_ready, 1'b1);
        send(0, NV, 0, NV);
        wait_done(50);
        chk("rs_pass", pass, 1'b1);

        // skew: A fills its FIFO while B is silent
        new_words(-1);
        pulse_start();
        send(0, DEPTH, 0, 0);
        chk("skew_a_full", a_ready, 1'b0);
        idle_tick();
        chk("skew_no_cmp", cmp_count, 16'd0);
        send(DEPTH, NV, 0, NV);
        wait_done(50);
        chk("skew_cmp", cmp_count, 16'd20);
        chk("skew_pass", pass, 1'b1);

        // timeout with both streams idle
        pulse_start();
        t0 = n_ticks;
        wait_done(200);
        chk("to_latency", n_ticks - t0, TO);
        chk("to_flag", timeout, 1'b1);
        chk("to_pass", pass, 1'b0);
        chk("to_cmp", cmp_count, 16'd0);

        // reset mid-run with words still queued
        new_words(-1);
        pulse_start();
        send(0, 7, 0, 5);
        for (int i = 0; i < 4 && m_cmp < 5; i++) idle_tick();
        chk("mid_cmp", cmp_count, 16'd5);
        rst = 1'b1;
        idle_tick();
        rst = 1'b0;
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_cmp", cmp_count, 16'd0);
        chk("mid_rst_sig", signature, 32'h0);
        a_valid = 1'b1;
        a_data  = wa[0];
        idle_tick();
        a_valid = 1'b0;
        chk("mid_idle_ready", a_ready, 1'b0);
        new_words(-1);
        pulse_start();
        send(0, NV, 0, NV);
        wait_done(50);
        chk("mid_pass", pass, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
